// File: rtl/itoaer.sv
`default_nettype none
// itoaer: writes a 32-bit value as signed-decimal or unsigned-hex ASCII, MS char first, to byte memory.
// Revision 1.0
module itoaer #(
  parameter int DSZ = 32,
  parameter int ASZ = 17,
  parameter int MSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           hex,
  input  logic [DSZ-1:0] vi,
  input  logic [ASZ-1:0] ai,
  output logic           bsy,
  output logic [3:0]     len,
  output logic [ASZ-1:0] ao,
  output logic           mb_we,
  output logic [ASZ-1:0] mb_ai,
  output logic [MSZ-1:0] mb_vi
);

  typedef enum logic [2:0] {RDY, SGN, DEC, HEX, DONE} state_t;

  state_t         state_q, state_d;
  logic [DSZ-1:0] rem_q, rem_d;
  logic [ASZ-1:0] p_q, p_d;
  logic [3:0]     len_q, len_d;
  logic [3:0]     k_q, k_d;
  logic [3:0]     d_q, d_d;
  logic           started_q, started_d;
  logic           hex_q, hex_d;

  logic [DSZ-1:0] pow;
  logic [3:0]     nib;
  logic           emit;
  logic [MSZ-1:0] chr;

  always_comb begin
    case (k_q)
      4'd0:    pow = 32'd1;
      4'd1:    pow = 32'd10;
      4'd2:    pow = 32'd100;
      4'd3:    pow = 32'd1000;
      4'd4:    pow = 32'd10000;
      4'd5:    pow = 32'd100000;
      4'd6:    pow = 32'd1000000;
      4'd7:    pow = 32'd10000000;
      4'd8:    pow = 32'd100000000;
      4'd9:    pow = 32'd1000000000;
      default: pow = 32'd1;
    endcase
  end

  assign nib = rem_q[{k_q[2:0], 2'b00} +: 4];

  // Every action below is gated by en so an abort cycle never writes.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    p_d       = p_q;
    len_d     = len_q;
    k_d       = k_q;
    d_d       = d_q;
    started_d = started_q;
    hex_d     = hex_q;
    emit      = 1'b0;
    chr       = 8'h00;
    case (state_q)
      RDY: begin
        if (en) begin
          rem_d     = vi;
          p_d       = ai;
          hex_d     = hex;
          len_d     = 4'd0;
          started_d = 1'b0;
          state_d   = SGN;
        end
      end
      SGN: begin
        if (!en) begin
          state_d = RDY;
        end else begin
          if (!hex_q && rem_q[DSZ-1]) begin
            emit  = 1'b1;
            chr   = 8'h2D;
            rem_d = -rem_q;
          end
          d_d     = 4'd0;
          k_d     = hex_q ? 4'd7 : 4'd9;
          state_d = hex_q ? HEX : DEC;
        end
      end
      DEC: begin
        if (!en) begin
          state_d = RDY;
        end else if (rem_q >= pow) begin
          rem_d = rem_q - pow;
          d_d   = d_q + 4'd1;
        end else begin
          if (d_q != 4'd0 || started_q || k_q == 4'd0) begin
            emit      = 1'b1;
            chr       = 8'h30 + {4'h0, d_q};
            started_d = 1'b1;
          end
          d_d = 4'd0;
          k_d = k_q - 4'd1;
          if (k_q == 4'd0) state_d = DONE;
        end
      end
      HEX: begin
        if (!en) begin
          state_d = RDY;
        end else begin
          if (nib != 4'd0 || started_q || k_q == 4'd0) begin
            emit      = 1'b1;
            chr       = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
            started_d = 1'b1;
          end
          k_d = k_q - 4'd1;
          if (k_q == 4'd0) state_d = DONE;
        end
      end
      DONE: begin
        if (!en) state_d = RDY;
      end
      default: state_d = RDY;
    endcase
    if (emit) begin
      p_d   = p_q + ASZ'(1);
      len_d = len_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RDY;
      rem_q     <= '0;
      p_q       <= '0;
      len_q     <= 4'd0;
      k_q       <= 4'd0;
      d_q       <= 4'd0;
      started_q <= 1'b0;
      hex_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      p_q       <= p_d;
      len_q     <= len_d;
      k_q       <= k_d;
      d_q       <= d_d;
      started_q <= started_d;
      hex_q     <= hex_d;
    end
  end

  assign bsy   = (state_q == SGN) || (state_q == DEC) || (state_q == HEX);
  assign len   = len_q;
  assign ao    = p_q;
  assign mb_we = emit;
  assign mb_ai = p_q;
  assign mb_vi = chr;

endmodule
`default_nettype wire
